// File: rtl/tisc_pkg.sv
// Shared TISC core definitions: register-file defaults, clear FSM states,
// and the address-legality rule used by both the file and its scoreboard.
package tisc_pkg;

  localparam int unsigned RF_WIDTH = 8;
  localparam int unsigned RF_DEPTH = 8;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } rf_state_t;

  // An address is live when it names a real entry and is not the hard-wired zero.
  function automatic logic rf_addr_ok(input int unsigned addr,
                                      input int unsigned depth,
                                      input bit          zero_reg);
    return (addr < depth) && !(zero_reg && (addr == 0));
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set on issue,
// cleared on writeback, with the issue-stall check against the pre-edge bit.
module rf_scoreboard
  import tisc_pkg::*;
#(
  parameter  int unsigned DEPTH    = RF_DEPTH,
  parameter  bit          ZERO_REG = 1'b1,
  localparam int unsigned AW       = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          run_i,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic          iss_en_i,
  input  logic [AW-1:0] iss_addr_i,
  input  logic [AW-1:0] rd_addr_1_i,
  input  logic [AW-1:0] rd_addr_2_i,
  output logic          iss_stall_o,
  output logic          busy_1_o,
  output logic          busy_2_o
);

  logic [DEPTH-1:0] busy_q, busy_d;
  logic             wr_ok, iss_ok, rd1_ok, rd2_ok;

  assign wr_ok  = rf_addr_ok(32'(wr_addr_i), DEPTH, ZERO_REG);
  assign iss_ok = rf_addr_ok(32'(iss_addr_i), DEPTH, ZERO_REG);
  assign rd1_ok = rf_addr_ok(32'(rd_addr_1_i), DEPTH, ZERO_REG);
  assign rd2_ok = rf_addr_ok(32'(rd_addr_2_i), DEPTH, ZERO_REG);

  // Next busy vector: writeback clears first so a same-cycle issue to the
  // same register leaves it busy.
  always_comb begin
    busy_d = busy_q;
    if (run_i) begin
      if (wr_en_i && wr_ok) begin
        busy_d[wr_addr_i] = 1'b0;
      end
      if (iss_en_i && iss_ok && !busy_q[iss_addr_i]) begin
        busy_d[iss_addr_i] = 1'b1;
      end
    end
  end

  // Busy vector register; reset empties the scoreboard.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // Stall and read-side busy flags, all from the pre-edge busy bits.
  always_comb begin
    iss_stall_o = run_i && iss_en_i && iss_ok && busy_q[iss_addr_i];
    busy_1_o    = run_i && rd1_ok && busy_q[rd_addr_1_i];
    busy_2_o    = run_i && rd2_ok && busy_q[rd_addr_2_i];
  end

endmodule

// File: rtl/regfile_sb.sv
// 2-read/1-write register file with clear-after-reset FSM, optional
// write-to-read bypass, optional hard-wired zero register and scoreboard.
module regfile_sb
  import tisc_pkg::*;
#(
  parameter  int unsigned WIDTH    = RF_WIDTH,
  parameter  int unsigned DEPTH    = RF_DEPTH,
  parameter  bit          ZERO_REG = 1'b1,
  parameter  bit          BYPASS   = 1'b1,
  localparam int unsigned AW       = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  output logic             ready,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             iss_en,
  input  logic [AW-1:0]    iss_addr,
  output logic             iss_stall,
  input  logic [AW-1:0]    rd_addr_1,
  output logic [WIDTH-1:0] rd_data_1,
  output logic             rd_busy_1,
  input  logic [AW-1:0]    rd_addr_2,
  output logic [WIDTH-1:0] rd_data_2,
  output logic             rd_busy_2
);

  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

  rf_state_t        state_q, state_d;
  logic [AW-1:0]    clr_ptr_q, clr_ptr_d;
  logic [WIDTH-1:0] regs_q [DEPTH];
  logic             run, wr_hit, sb_busy_1, sb_busy_2;

  assign run    = (state_q == RUN);
  assign ready  = run;
  assign wr_hit = run && wr_en && rf_addr_ok(32'(wr_addr), DEPTH, ZERO_REG);

  rf_scoreboard #(
    .DEPTH    (DEPTH),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk_i       (clk),
    .rst_i       (rst),
    .run_i       (run),
    .wr_en_i     (wr_en),
    .wr_addr_i   (wr_addr),
    .iss_en_i    (iss_en),
    .iss_addr_i  (iss_addr),
    .rd_addr_1_i (rd_addr_1),
    .rd_addr_2_i (rd_addr_2),
    .iss_stall_o (iss_stall),
    .busy_1_o    (sb_busy_1),
    .busy_2_o    (sb_busy_2)
  );

  // Clear FSM next state: walk every entry once, then open for traffic.
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    case (state_q)
      CLEAR: begin
        clr_ptr_d = clr_ptr_q + AW'(1);
        if (clr_ptr_q == LAST_PTR) begin
          state_d   = RUN;
          clr_ptr_d = '0;
        end
      end
      RUN:     state_d = RUN;
      default: state_d = CLEAR;
    endcase
  end

  // Clear FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLEAR;
      clr_ptr_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  // Storage: zeroing walk while clearing, writeback once running.
  always_ff @(posedge clk) begin
    if (state_q == CLEAR) begin
      regs_q[clr_ptr_q] <= '0;
    end else if (wr_hit) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  // Read ports: a bypassed read sees the incoming data, so its busy bit
  // reads as already cleared by that write.
  always_comb begin
    rd_data_1 = '0;
    rd_busy_1 = 1'b0;
    if (run && rf_addr_ok(32'(rd_addr_1), DEPTH, ZERO_REG)) begin
      if (BYPASS && wr_hit && (wr_addr == rd_addr_1)) begin
        rd_data_1 = wr_data;
      end else begin
        rd_data_1 = regs_q[rd_addr_1];
        rd_busy_1 = sb_busy_1;
      end
    end
    rd_data_2 = '0;
    rd_busy_2 = 1'b0;
    if (run && rf_addr_ok(32'(rd_addr_2), DEPTH, ZERO_REG)) begin
      if (BYPASS && wr_hit && (wr_addr == rd_addr_2)) begin
        rd_data_2 = wr_data;
      end else begin
        rd_data_2 = regs_q[rd_addr_2];
        rd_busy_2 = sb_busy_2;
      end
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: two instances (default config, and DEPTH=6 without
// zero register or bypass) share stimulus and are checked against a model.
module tb_regfile_sb;

  localparam int W  = 8;
  localparam int AW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, wr_en, iss_en;
  logic [AW-1:0] wr_addr, iss_addr, rd_addr_1, rd_addr_2;
  logic [W-1:0]  wr_data;

  logic          ready_a, stall_a, b1_a, b2_a;
  logic [W-1:0]  d1_a, d2_a;
  logic          ready_b, stall_b, b1_b, b2_b;
  logic [W-1:0]  d1_b, d2_b;

  regfile_sb #(.WIDTH(8), .DEPTH(8), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut_a (
    .clk(clk), .rst(rst), .ready(ready_a),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .iss_stall(stall_a),
    .rd_addr_1(rd_addr_1), .rd_data_1(d1_a), .rd_busy_1(b1_a),
    .rd_addr_2(rd_addr_2), .rd_data_2(d2_a), .rd_busy_2(b2_a)
  );

  regfile_sb #(.WIDTH(8), .DEPTH(6), .ZERO_REG(1'b0), .BYPASS(1'b0)) dut_b (
    .clk(clk), .rst(rst), .ready(ready_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .iss_stall(stall_b),
    .rd_addr_1(rd_addr_1), .rd_data_1(d1_b), .rd_busy_1(b1_b),
    .rd_addr_2(rd_addr_2), .rd_data_2(d2_b), .rd_busy_2(b2_b)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model, index 0 = dut_a, 1 = dut_b.
  logic [W-1:0] mem_m  [2][8];
  bit           busy_m [2][8];
  bit           run_m  [2];
  int unsigned  cnt_m  [2];

  function automatic int unsigned dep(input int c);
    return (c == 0) ? 8 : 6;
  endfunction
  function automatic bit zr(input int c);
    return (c == 0);
  endfunction
  function automatic bit byp(input int c);
    return (c == 0);
  endfunction
  function automatic bit ok(input int c, input logic [AW-1:0] a);
    return (int'(a) < int'(dep(c))) && !(zr(c) && a == 0);
  endfunction
  function automatic bit wr_hit(input int c);
    return run_m[c] && wr_en && ok(c, wr_addr);
  endfunction
  function automatic logic [W-1:0] exp_data(input int c, input logic [AW-1:0] a);
    if (!run_m[c] || !ok(c, a)) return '0;
    if (byp(c) && wr_hit(c) && wr_addr == a) return wr_data;
    return mem_m[c][a];
  endfunction
  function automatic bit exp_busy(input int c, input logic [AW-1:0] a);
    if (!run_m[c] || !ok(c, a)) return 1'b0;
    if (byp(c) && wr_hit(c) && wr_addr == a) return 1'b0;
    return busy_m[c][a];
  endfunction
  function automatic bit exp_stall(input int c);
    return run_m[c] && iss_en && ok(c, iss_addr) && busy_m[c][iss_addr];
  endfunction

  task automatic model_edge();
    for (int c = 0; c < 2; c++) begin
      if (rst) begin
        run_m[c] = 1'b0;
        cnt_m[c] = 0;
        for (int r = 0; r < 8; r++) busy_m[c][r] = 1'b0;
      end else if (!run_m[c]) begin
        cnt_m[c]++;
        if (cnt_m[c] == dep(c)) begin
          run_m[c] = 1'b1;
          for (int r = 0; r < 8; r++) mem_m[c][r] = '0;
        end
      end else begin
        bit pre;
        pre = busy_m[c][iss_addr];
        if (wr_hit(c)) begin
          mem_m[c][wr_addr]  = wr_data;
          busy_m[c][wr_addr] = 1'b0;
        end
        if (iss_en && ok(c, iss_addr) && !pre) busy_m[c][iss_addr] = 1'b1;
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sample();
    @(negedge clk);
    check("a.ready", 32'(ready_a), 32'(run_m[0]));
    check("a.rd1",   32'(d1_a),    32'(exp_data(0, rd_addr_1)));
    check("a.rd2",   32'(d2_a),    32'(exp_data(0, rd_addr_2)));
    check("a.busy1", 32'(b1_a),    32'(exp_busy(0, rd_addr_1)));
    check("a.busy2", 32'(b2_a),    32'(exp_busy(0, rd_addr_2)));
    check("a.stall", 32'(stall_a), 32'(exp_stall(0)));
    check("b.ready", 32'(ready_b), 32'(run_m[1]));
    check("b.rd1",   32'(d1_b),    32'(exp_data(1, rd_addr_1)));
    check("b.rd2",   32'(d2_b),    32'(exp_data(1, rd_addr_2)));
    check("b.busy1", 32'(b1_b),    32'(exp_busy(1, rd_addr_1)));
    check("b.busy2", 32'(b2_b),    32'(exp_busy(1, rd_addr_2)));
    check("b.stall", 32'(stall_b), 32'(exp_stall(1)));
  endtask

  task automatic advance();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic tick();
    sample();
    advance();
  endtask

  task automatic idle();
    wr_en = 1'b0; iss_en = 1'b0; wr_data = '0;
    wr_addr = '0; iss_addr = '0;
  endtask

  int lat_a, lat_b;

  initial begin
    for (int c = 0; c < 2; c++) begin
      run_m[c] = 1'b0; cnt_m[c] = 0;
      for (int r = 0; r < 8; r++) begin mem_m[c][r] = '0; busy_m[c][r] = 1'b0; end
    end
    rst = 1'b1; idle(); rd_addr_1 = '0; rd_addr_2 = '0;
    @(posedge clk);
    model_edge();
    #1;
    tick();
    tick();

    // Clear latency after reset release.
    rst = 1'b0; lat_a = 0; lat_b = 0;
    for (int i = 0; i < 12; i++) begin
      rd_addr_1 = AW'(i % 8); rd_addr_2 = AW'((i + 3) % 8);
      if (!ready_a) lat_a++;
      if (!ready_b) lat_b++;
      tick();
    end
    check("ready_latency_a", 32'(lat_a), 32'd8);
    check("ready_latency_b", 32'(lat_b), 32'd6);

    // Write r3 with same-cycle read.
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 8'hA5; rd_addr_1 = 3'd3;
    sample();
    check("bypass_same_cycle", 32'(d1_a), 32'h0A5);
    check("nobypass_same_cycle", 32'(d1_b), 32'h000);
    advance();
    idle();
    sample();
    check("nobypass_next", 32'(d1_b), 32'h0A5);
    advance();

    // Zero register write and issue.
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 8'hFF;
    iss_en = 1'b1; iss_addr = 3'd0; rd_addr_1 = 3'd0;
    sample();
    check("zero_issue_stall", 32'(stall_a), 32'd0);
    advance();
    idle();
    sample();
    check("zero_reads_zero", 32'(d1_a), 32'h000);
    check("zero_never_busy", 32'(b1_a), 32'd0);
    advance();

    // Double issue to r5, then writeback.
    iss_en = 1'b1; iss_addr = 3'd5; rd_addr_2 = 3'd5;
    tick();
    sample();
    check("reissue_stall", 32'(stall_a), 32'd1);
    check("r5_busy", 32'(b2_a), 32'd1);
    advance();
    idle();
    wr_en = 1'b1; wr_addr = 3'd5; wr_data = 8'h3C;
    sample();
    check("wb_bypass_busy", 32'(b2_a), 32'd0);
    check("wb_bypass_data", 32'(d2_a), 32'h03C);
    advance();

    // Same-cycle issue and write to r2.
    idle();
    iss_en = 1'b1; iss_addr = 3'd2; wr_en = 1'b1; wr_addr = 3'd2; wr_data = 8'h11;
    rd_addr_1 = 3'd2;
    tick();
    idle();
    sample();
    check("r2_data", 32'(d1_a), 32'h011);
    check("r2_busy", 32'(b1_a), 32'd1);
    advance();

    // Reset pulse in RUN re-clears contents and scoreboard.
    wr_en = 1'b1; wr_addr = 3'd7; wr_data = 8'h77;
    tick();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    rd_addr_1 = 3'd7;
    sample();
    check("r7_after_reset", 32'(d1_a), 32'h000);
    advance();
    for (int r = 0; r < 8; r++) begin
      rd_addr_1 = AW'(r); rd_addr_2 = AW'(7 - r);
      tick();
    end

    // Randomised traffic, occasional resets.
    for (int i = 0; i < 400; i++) begin
      rst      = ($urandom_range(0, 79) == 0);
      wr_en    = $urandom_range(0, 1) == 1;
      wr_addr  = AW'($urandom_range(0, 7));
      wr_data  = W'($urandom);
      iss_en   = $urandom_range(0, 2) != 0;
      iss_addr = AW'($urandom_range(0, 7));
      rd_addr_1 = ($urandom_range(0, 3) == 0) ? wr_addr : AW'($urandom_range(0, 7));
      rd_addr_2 = ($urandom_range(0, 3) == 0) ? iss_addr : AW'($urandom_range(0, 7));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
